// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing defaults, address-width helper and address type for the register file
package regfile_pkg;
  localparam int DEFAULT_DATA_W   = 64;
  localparam int DEFAULT_NUM_REGS = 32;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef logic [clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_core.sv
// regfile_sb_core: per-register pending-writeback busy bits with flush > reserve > release priority
module regfile_sb_core
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1,
  localparam int AW = clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic                write_i,
  input  logic [AW-1:0]       write_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  // next busy: a reserve beats a same-cycle release since a newer producer is in flight
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++)
      busy_d[n] = flush_i ? 1'b0 :
                  (rsv_i && rsv_addr_i == AW'(n)) ? 1'b1 :
                  (write_i && write_addr_i == AW'(n)) ? 1'b0 : busy_q[n];
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end
  // busy vector register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with busy scoreboard; REGFILE_MP_SB_WR_BYPASS_EN enables write-to-read bypass
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD-1:0]        i_read,
  input  logic [NUM_RD*AW-1:0]     i_read_addr,
  output logic [NUM_RD*DATA_W-1:0] o_read_data,
  output logic [NUM_RD-1:0]        o_read_busy,
  input  logic                     i_write,
  input  logic [AW-1:0]            i_write_addr,
  input  logic [DATA_W-1:0]        i_write_data,
  input  logic                     i_rsv,
  input  logic [AW-1:0]            i_rsv_addr,
  input  logic                     i_flush,
  output logic [NUM_REGS-1:0]      o_busy_vec
);
  logic [DATA_W-1:0]             regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]           busy_vec;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]             rd_busy_q;
  logic [DATA_W-1:0]             rd_data_d [NUM_RD];
  logic                          rd_busy_d [NUM_RD];
  logic                          wr_en;
  assign wr_en = i_write && !(ZERO_REG != 0 && i_write_addr == '0);
  regfile_sb_core #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .flush_i     (i_flush),
    .rsv_i       (i_rsv),
    .rsv_addr_i  (i_rsv_addr),
    .write_i     (i_write),
    .write_addr_i(i_write_addr),
    .busy_o      (busy_vec)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          zr;
    assign a  = i_read_addr[k*AW +: AW];
    assign zr = ZERO_REG != 0 && a == '0;
`ifdef REGFILE_MP_SB_WR_BYPASS_EN
    logic hit;
    assign hit          = i_write && i_write_addr == a;
    assign rd_data_d[k] = zr ? '0 : hit ? i_write_data : regs_q[a];
    assign rd_busy_d[k] = zr ? 1'b0 : hit ? (i_rsv && !i_flush && i_rsv_addr == a) : busy_vec[a];
`else
    assign rd_data_d[k] = zr ? '0 : regs_q[a];
    assign rd_busy_d[k] = zr ? 1'b0 : busy_vec[a];
`endif
  end
  // register storage; writes to the hardwired zero register are dropped
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
    else if (wr_en) regs_q[i_write_addr] <= i_write_data;
  // read ports capture on request and hold otherwise
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else
      for (int k = 0; k < NUM_RD; k++)
        if (i_read[k]) begin
          rd_data_q[k] <= rd_data_d[k];
          rd_busy_q[k] <= rd_busy_d[k];
        end
  assign o_read_data = rd_data_q;
  assign o_read_busy = rd_busy_q;
  assign o_busy_vec  = busy_vec;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench for regfile_mp_sb against an array-based reference model
module tb_regfile_mp_sb;
  import regfile_pkg::*;
`ifdef REGFILE_MP_SB_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [1:0]   i_read = '0;
  logic [9:0]   i_read_addr = '0;
  logic [127:0] o_read_data;
  logic [1:0]   o_read_busy;
  logic         i_write = 1'b0;
  reg_addr_t    i_write_addr = '0;
  logic [63:0]  i_write_data = '0;
  logic         i_rsv = 1'b0;
  reg_addr_t    i_rsv_addr = '0;
  logic         i_flush = 1'b0;
  logic [31:0]  o_busy_vec;
  typedef struct {
    logic [1:0][63:0] d;
    logic [1:0]       b;
    logic [31:0]      v;
  } exp_t;
  exp_t        q[$];
  exp_t        m_out;
  exp_t        e;
  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  int          tests = 0;
  int          fails = 0;

  regfile_mp_sb dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_read      (i_read),
    .i_read_addr (i_read_addr),
    .o_read_data (o_read_data),
    .o_read_busy (o_read_busy),
    .i_write     (i_write),
    .i_write_addr(i_write_addr),
    .i_write_data(i_write_data),
    .i_rsv       (i_rsv),
    .i_rsv_addr  (i_rsv_addr),
    .i_flush     (i_flush),
    .o_busy_vec  (o_busy_vec)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 32; n++) m_regs[n] = '0;
    m_busy  = '0;
    m_out.d = '0;
    m_out.b = '0;
    m_out.v = '0;
  endtask

  // one clock of stimulus; expected outputs after the edge go to the scoreboard queue
  task automatic cyc(input logic [1:0] rd, input reg_addr_t a0, input reg_addr_t a1,
                     input logic w, input reg_addr_t wa, input logic [63:0] wd,
                     input logic rs, input reg_addr_t rsa, input logic fl);
    reg_addr_t ra [2];
    logic      hit;
    ra[0] = a0;
    ra[1] = a1;
    @(negedge i_clk);
    i_read = rd;
    i_read_addr = {a1, a0};
    i_write = w;
    i_write_addr = wa;
    i_write_data = wd;
    i_rsv = rs;
    i_rsv_addr = rsa;
    i_flush = fl;
    for (int k = 0; k < 2; k++)
      if (rd[k]) begin
        hit = BYP && w && wa == ra[k];
        m_out.d[k] = (ra[k] == 0) ? 64'd0 : hit ? wd : m_regs[ra[k]];
        m_out.b[k] = (ra[k] == 0) ? 1'b0 : hit ? (rs && !fl && rsa == ra[k]) : m_busy[ra[k]];
      end
    if (w && wa != 0) m_regs[wa] = wd;
    if (fl) m_busy = '0;
    else begin
      if (w) m_busy[wa] = 1'b0;
      if (rs && rsa != 0) m_busy[rsa] = 1'b1;
    end
    m_out.v = m_busy;
    q.push_back(m_out);
  endtask

  task automatic idle();
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
  endtask

  // monitor: after every edge compare the outputs against the oldest expectation
  initial forever begin
    @(posedge i_clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rd_data0", o_read_data[63:0], e.d[0]);
      check("rd_data1", o_read_data[127:64], e.d[1]);
      check("rd_busy", 64'(o_read_busy), 64'(e.b));
      check("busy_vec", 64'(o_busy_vec), 64'(e.v));
    end
  end

  initial begin
    model_reset();
    #3;
    check("rst_data", o_read_data[63:0] | o_read_data[127:64], 64'd0);
    check("rst_busy", 64'(o_read_busy), 64'd0);
    check("rst_vec", 64'(o_busy_vec), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(2'b00, 0, 0, 1'b1, 7, 64'hDEADBEEF_00000001, 1'b0, 0, 1'b0);
    cyc(2'b11, 7, 7, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cyc(2'b00, 0, 0, 1'b1, 0, 64'h1234, 1'b1, 0, 1'b0);
    cyc(2'b11, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 3, 1'b0);
    cyc(2'b01, 3, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cyc(2'b00, 0, 0, 1'b1, 3, 64'h55, 1'b0, 0, 1'b0);
    cyc(2'b10, 0, 3, 1'b1, 3, 64'h77, 1'b1, 3, 1'b0);
    cyc(2'b11, 3, 3, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 4, 1'b0);
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 9, 1'b0);
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 12, 1'b1);
    idle();
    cyc(2'b00, 0, 0, 1'b1, 10, 64'h11, 1'b0, 0, 1'b0);
    cyc(2'b01, 10, 0, 1'b1, 10, 64'hAA, 1'b0, 0, 1'b0);
    cyc(2'b10, 0, 10, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cyc(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 5, 1'b0);
    @(negedge i_clk);
    i_read = 2'b00;
    i_rsv = 1'b0;
    i_write = 1'b1;
    i_write_addr = 5;
    i_write_data = 64'hCAFE_F00D_0000_0005;
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_data", o_read_data[63:0] | o_read_data[127:64], 64'd0);
    check("mid_rst_busy", 64'(o_read_busy), 64'd0);
    check("mid_rst_vec", 64'(o_busy_vec), 64'd0);
    q.delete();
    model_reset();
    i_write = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(2'b01, 5, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    repeat (400)
      cyc(2'($urandom), reg_addr_t'($urandom_range(0, 15)), reg_addr_t'($urandom_range(0, 15)),
          1'($urandom), reg_addr_t'($urandom_range(0, 15)), {$urandom, $urandom},
          $urandom_range(0, 2) == 0, reg_addr_t'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
    repeat (3) idle();
    @(negedge i_clk);
    @(negedge i_clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
